// File: rtl/if_fetch_unit.sv
// RV32 instruction fetch: one outstanding imem request feeding an in-order {pc, instruction} buffer.
// Build option IF_PREFETCH_EN: 2-entry buffer so a request can issue alongside the previous response.
package PipelineReg;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instruction;
  } ID_STATE;
endpackage

module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 stall,
  input  logic                 kill,
  input  logic [31:0]          redirect_pc,
  output logic                 imem_req,
  output logic [31:0]          imem_addr,
  input  logic                 imem_rvalid,
  input  logic [31:0]          imem_rdata,
  output PipelineReg::ID_STATE id_state,
  output logic                 valid
);
  // state | meaning
  // IDLE  | no request outstanding
  // WAIT  | request outstanding, its response is pushed into the buffer
  // DROP  | killed request outstanding, its response is discarded

`ifdef IF_PREFETCH_EN
  localparam int BUF_DEPTH = 2;
`else
  localparam int BUF_DEPTH = 1;
`endif
  localparam int CNT_W = $clog2(BUF_DEPTH + 1);

  typedef enum logic [1:0] {IDLE, WAIT, DROP} state_t;

  state_t               state, state_nxt;
  PipelineReg::ID_STATE fifo_q [BUF_DEPTH];
  logic [CNT_W-1:0]     count, count_nxt, wr_idx;
  logic [31:0]          fetch_pc, req_pc;
  logic                 pop, push, resp_done, full;

  assign valid    = (count != '0);
  assign id_state = fifo_q[0];

  always_comb begin
    pop       = valid && !stall && !kill;
    push      = !kill && (state == WAIT) && imem_rvalid;
    resp_done = (state != IDLE) && imem_rvalid;
    wr_idx    = count - CNT_W'(pop);
    count_nxt = count + CNT_W'(push) - CNT_W'(pop);
    full      = (count == CNT_W'(BUF_DEPTH));
    // a new request needs a free slot once this cycle's push/pop has settled
    imem_req  = !rst && !kill && ((state == IDLE) || resp_done) &&
                (count_nxt < CNT_W'(BUF_DEPTH));
    imem_addr = imem_req ? fetch_pc : 32'h0;
  end

  always_comb begin
    state_nxt = state;
    if (kill) begin
      // a response landing in the kill cycle closes out the request
      if (state != IDLE) state_nxt = imem_rvalid ? IDLE : DROP;
    end else if (imem_req) begin
      state_nxt = WAIT;
    end else if (resp_done) begin
      state_nxt = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      fetch_pc <= RESET_PC;
      req_pc   <= '0;
      count    <= '0;
      for (int i = 0; i < BUF_DEPTH; i++) fifo_q[i] <= '0;
    end else begin
      state <= state_nxt;
      if (kill)          fetch_pc <= redirect_pc & ~32'h3;
      else if (imem_req) fetch_pc <= fetch_pc + 32'd4;
      if (imem_req) req_pc <= fetch_pc;
      if (kill) begin
        count <= '0;
      end else begin
        count <= count_nxt;
        if (pop)
          for (int i = 0; i < BUF_DEPTH - 1; i++) fifo_q[i] <= fifo_q[i+1];
        if (push)
          for (int i = 0; i < BUF_DEPTH; i++)
            if (CNT_W'(i) == wr_idx) fifo_q[i] <= '{pc: req_pc, instruction: imem_rdata};
      end
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(push && full && !pop));

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: directed start-up/stall/kill/reset scenarios plus random traffic,
// scored against a program-order model of fetch addresses and delivered instructions.
module tb_if_fetch_unit;
  import PipelineReg::*;

  localparam logic [31:0] RST_PC  = 32'h100;
  localparam logic [31:0] MAGIC   = 32'hA5A5_0000;
  localparam int          GAP_MAX = 16;
`ifdef IF_PREFETCH_EN
  localparam int SPACING = 1;
`else
  localparam int SPACING = 2;
`endif

  logic        clk = 1'b0;
  logic        rst, stall, kill, imem_req, imem_rvalid, valid;
  logic [31:0] redirect_pc, imem_addr, imem_rdata;
  ID_STATE     id_state;

  int n_cmp = 0;
  int n_bad = 0;

  // memory model: single in-order outstanding request
  logic        pend;
  logic [31:0] pend_addr;
  int          pend_cyc, pend_lat, fixed_lat, cyc;
  logic        random_lat;

  logic        s_req, s_valid;
  logic [31:0] s_addr;
  ID_STATE     s_id;

  // reference: next address to be requested, next pc to be delivered
  logic [31:0] exp_fetch, exp_pc;
  int          gap;
  logic        hold_pend;
  ID_STATE     hold_id;
  logic        found;
  int          c10c;

  if_fetch_unit #(.RESET_PC(RST_PC)) dut (
    .clk(clk), .rst(rst), .stall(stall), .kill(kill), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rvalid(imem_rvalid),
    .imem_rdata(imem_rdata), .id_state(id_state), .valid(valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic cycle();
    if (pend && (cyc - pend_cyc) >= pend_lat) begin
      imem_rvalid = 1'b1;
      imem_rdata  = pend_addr ^ MAGIC;
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = $urandom;
    end
    @(negedge clk);
    s_req = imem_req; s_addr = imem_addr; s_valid = valid; s_id = id_state;
    if (!rst) begin
      if (hold_pend) begin
        check("stall_hold_valid", 32'(s_valid), 32'd1);
        check("stall_hold_pc", s_id.pc, hold_id.pc);
        check("stall_hold_instr", s_id.instruction, hold_id.instruction);
      end
      hold_pend = s_valid && stall && !kill;
      hold_id   = s_id;
      if (kill) check("kill_no_req", 32'(s_req), 32'd0);
      if (s_req) begin
        check("imem_addr", s_addr, exp_fetch);
        check("one_outstanding", 32'(pend && !imem_rvalid), 32'd0);
        exp_fetch = exp_fetch + 32'd4;
      end
      if (kill) exp_fetch = redirect_pc & ~32'h3;
      if (s_valid && !stall && !kill) begin
        check("pop_pc", s_id.pc, exp_pc);
        check("pop_instr", s_id.instruction, exp_pc ^ MAGIC);
        check("pop_gap", 32'(gap <= GAP_MAX), 32'd1);
        exp_pc = exp_pc + 32'd4;
        gap = 0;
      end else if (!stall) begin
        gap++;
      end
      if (kill) begin
        exp_pc = redirect_pc & ~32'h3;
        gap = 0;
      end
    end
    @(posedge clk);
    #1;
    if (rst) begin
      pend = 1'b0; exp_fetch = RST_PC; exp_pc = RST_PC; gap = 0; hold_pend = 1'b0;
    end else begin
      if (imem_rvalid) pend = 1'b0;
      if (s_req) begin
        pend      = 1'b1;
        pend_addr = s_addr;
        pend_cyc  = cyc;
        pend_lat  = random_lat ? int'($urandom_range(3, 1)) : fixed_lat;
      end
    end
    cyc++;
  endtask

  task automatic run_until_req(input int budget);
    found = 1'b0;
    for (int i = 0; i < budget && !found; i++) begin
      cycle();
      found = s_req;
    end
  endtask

  task automatic run_until_valid(input int budget);
    found = 1'b0;
    for (int i = 0; i < budget && !found; i++) begin
      cycle();
      found = s_valid;
    end
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; kill = 1'b0; redirect_pc = '0;
    imem_rvalid = 1'b0; imem_rdata = '0;
    pend = 1'b0; pend_addr = '0; pend_cyc = 0; pend_lat = 1; fixed_lat = 1; cyc = 0;
    random_lat = 1'b0; exp_fetch = RST_PC; exp_pc = RST_PC; gap = 0; hold_pend = 1'b0;
    hold_id = '0; found = 1'b0; c10c = 0;

    // reset state and start-up timing
    cycle(); cycle();
    check("rst_valid", 32'(s_valid), 32'd0);
    check("rst_id_pc", s_id.pc, 32'd0);
    check("rst_id_instr", s_id.instruction, 32'd0);
    check("rst_req", 32'(s_req), 32'd0);
    check("rst_addr", s_addr, 32'd0);
    rst = 1'b0;
    cycle();
    check("start_req", 32'(s_req), 32'd1);
    check("start_addr", s_addr, RST_PC);
    cycle();
    check("start_c1_valid", 32'(s_valid), 32'd0);
    cycle();
    check("start_c2_valid", 32'(s_valid), 32'd1);
    check("start_c2_pc", s_id.pc, 32'h100);
    check("start_c2_instr", s_id.instruction, 32'hA5A5_0100);
    for (int k = 1; k <= 1; k++) begin
      for (int j = 1; j < SPACING; j++) begin
        cycle();
        check("seq_gap_valid", 32'(s_valid), 32'd0);
      end
      cycle();
      check("seq_valid", 32'(s_valid), 32'd1);
      check("seq_pc", s_id.pc, RST_PC + 32'(4 * k));
    end

    // stall hold while 108 is at the head
    found = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (valid && id_state.pc == 32'h108) begin found = 1'b1; break; end
      cycle();
    end
    check("stall_start_found", 32'(found), 32'd1);
    stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cycle();
      check("stall_valid", 32'(s_valid), 32'd1);
      check("stall_pc", s_id.pc, 32'h108);
    end
    stall = 1'b0;
    cycle();
    check("release_pc", s_id.pc, 32'h108);
    run_until_valid(4);
    check("release_next_found", 32'(found), 32'd1);
    check("release_next_pc", s_id.pc, 32'h10C);

    // kill while the 10C request is outstanding on a 3-cycle memory
    rst = 1'b1; cycle(); rst = 1'b0; fixed_lat = 3;
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (pend && pend_addr == 32'h10C) begin found = 1'b1; break; end
      cycle();
    end
    check("kill_wait_found", 32'(found), 32'd1);
    c10c = pend_cyc;
    kill = 1'b1; redirect_pc = 32'h2000;
    cycle();
    kill = 1'b0;
    run_until_req(10);
    check("drop_req_found", 32'(found), 32'd1);
    check("drop_req_cycle", 32'(cyc - 1), 32'(c10c + 3));
    check("drop_req_addr", s_addr, 32'h2000);
    run_until_valid(10);
    check("redirect_valid_found", 32'(found), 32'd1);
    check("redirect_pc", s_id.pc, 32'h2000);
    check("redirect_instr", s_id.instruction, 32'hA5A5_2000);

    // kill with a response and a stall in the same cycle, 1-cycle memory
    fixed_lat = 1;
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (pend && (cyc - pend_cyc) >= pend_lat) begin found = 1'b1; break; end
      cycle();
    end
    check("kill_rv_found", 32'(found), 32'd1);
    kill = 1'b1; stall = 1'b1; redirect_pc = 32'h3000;
    cycle();
    kill = 1'b0; stall = 1'b0;
    cycle();
    check("kill_rv_k1_valid", 32'(s_valid), 32'd0);
    cycle();
    check("kill_rv_k2_valid", 32'(s_valid), 32'd0);
    cycle();
    check("kill_rv_k3_valid", 32'(s_valid), 32'd1);
    check("kill_rv_k3_pc", s_id.pc, 32'h3000);

    // misaligned redirect and address wrap
    kill = 1'b1; redirect_pc = 32'hFFFF_FFFE;
    cycle();
    kill = 1'b0;
    run_until_req(8);
    check("wrap_req1_found", 32'(found), 32'd1);
    check("wrap_addr1", s_addr, 32'hFFFF_FFFC);
    run_until_req(8);
    check("wrap_req2_found", 32'(found), 32'd1);
    check("wrap_addr2", s_addr, 32'h0000_0000);

    // reset with a request outstanding
    fixed_lat = 3;
    found = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (pend) begin found = 1'b1; break; end
      cycle();
    end
    check("midrst_pend_found", 32'(found), 32'd1);
    rst = 1'b1;
    cycle();
    check("midrst_req", 32'(s_req), 32'd0);
    rst = 1'b0;
    cycle();
    check("midrst_valid", 32'(s_valid), 32'd0);
    check("midrst_restart_req", 32'(s_req), 32'd1);
    check("midrst_restart_addr", s_addr, RST_PC);
    run_until_valid(10);
    check("midrst_valid_found", 32'(found), 32'd1);
    check("midrst_pc", s_id.pc, RST_PC);

    // random traffic against the reference
    random_lat = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      rst         = ($urandom_range(299, 0) == 0);
      stall       = ($urandom_range(3, 0) == 0);
      kill        = ($urandom_range(24, 0) == 0);
      redirect_pc = $urandom;
      cycle();
    end
    rst = 1'b0; stall = 1'b0; kill = 1'b0;
    for (int i = 0; i < 20; i++) cycle();
    check("final_gap", 32'(gap <= GAP_MAX), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
